// File: rtl/astro_pkg.sv
// Shared encodings for the AstroGenius frame serializer:
// FSM states, frame sections and object-record field offsets.
package astro_pkg;

    localparam logic [4:0] E_INICIAL    = 5'd0;
    localparam logic [4:0] E_ESPERA     = 5'd1;
    localparam logic [4:0] E_CAPTURA    = 5'd2;
    localparam logic [4:0] E_CARREGA    = 5'd3;
    localparam logic [4:0] E_INICIA_TX  = 5'd4;
    localparam logic [4:0] E_ESPERA_TX  = 5'd5;
    localparam logic [4:0] E_PROXIMO    = 5'd6;
    localparam logic [4:0] E_LE_MEM     = 5'd7;
    localparam logic [4:0] E_ESPERA_MEM = 5'd8;
    localparam logic [4:0] E_VERIFICA   = 5'd9;
    localparam logic [4:0] E_FIM        = 5'd10;
    localparam logic [4:0] E_ERRO       = 5'd31;

    localparam logic [2:0] S_PONT     = 3'd0;
    localparam logic [2:0] S_NAVE_OP  = 3'd1;
    localparam logic [2:0] S_NAVE_POS = 3'd2;
    localparam logic [2:0] S_ASTE     = 3'd3;
    localparam logic [2:0] S_TIRO     = 3'd4;
    localparam logic [2:0] S_ESPECIAL = 3'd5;
    localparam logic [2:0] S_RODAPE   = 3'd6;

    localparam logic [7:0] RODAPE_PADRAO = 8'hFF;

    // Record layout: {valid, opcode[7:0], position[8*bytes_pos-1:0]}
    function automatic int reg_obj_w(input int bytes_pos);
        return 9 + 8 * bytes_pos;
    endfunction

    function automatic int bit_valido(input int bytes_pos);
        return 8 + 8 * bytes_pos;
    endfunction

    function automatic int lsb_opcode(input int bytes_pos);
        return 8 * bytes_pos;
    endfunction

endpackage

// File: rtl/seletor_byte_quadro.sv
// Byte selector: picks the frame byte for the current section
// and byte index from the snapshot and the latched record.
module seletor_byte_quadro
    import astro_pkg::*;
#(
    parameter int         BYTES_POS   = 2,
    parameter int         BYTES_PONT  = 2,
    parameter logic [7:0] RODAPE_BYTE = RODAPE_PADRAO,
    parameter int         IW          = 3
) (
    input  logic [2:0]              secao,
    input  logic [IW-1:0]           idx,
    input  logic [8*BYTES_PONT-1:0] pont,
    input  logic [7:0]              nave_op,
    input  logic [8*BYTES_POS-1:0]  nave_pos,
    input  logic [7:0]              especial,
    input  logic [8*BYTES_POS+7:0]  obj,
    output logic [7:0]              byte_out
);

    logic [8*BYTES_PONT-1:0] desl_pont;
    logic [8*BYTES_POS-1:0]  desl_nave;
    logic [8*BYTES_POS-1:0]  desl_obj;

    // MSB byte first: shift the wanted byte down to bits [7:0]
    always_comb begin
        desl_pont = pont >> (8 * (BYTES_PONT - 1 - int'(idx)));
        desl_nave = nave_pos >> (8 * (BYTES_POS - 1 - int'(idx)));
        desl_obj  = obj[8*BYTES_POS-1:0] >> (8 * (BYTES_POS - int'(idx)));
        byte_out  = 8'h00;
        case (secao)
            S_PONT:     byte_out = desl_pont[7:0];
            S_NAVE_OP:  byte_out = nave_op;
            S_NAVE_POS: byte_out = desl_nave[7:0];
            S_ASTE,
            S_TIRO: begin
                if (idx == '0)
                    byte_out = obj[lsb_opcode(BYTES_POS)+:8];
                else
                    byte_out = desl_obj[7:0];
            end
            S_ESPECIAL: byte_out = especial;
            S_RODAPE:   byte_out = RODAPE_BYTE;
            default:    byte_out = 8'h00;
        endcase
    end

endmodule

// File: rtl/envia_quadro_serial.sv
// Frame serializer control: snapshots game state on request and
// streams score, ship, active objects, special move and footer.
module envia_quadro_serial
    import astro_pkg::*;
#(
    parameter int         N_ASTE       = 8,
    parameter int         N_TIROS      = 4,
    parameter int         BYTES_POS    = 2,
    parameter int         BYTES_PONT   = 2,
    parameter int         BYTES_RODAPE = 2,
    parameter logic [7:0] RODAPE_BYTE  = RODAPE_PADRAO,
    localparam int AW_A  = (N_ASTE > 1) ? $clog2(N_ASTE) : 1,
    localparam int AW_T  = (N_TIROS > 1) ? $clog2(N_TIROS) : 1,
    localparam int REG_W = reg_obj_w(BYTES_POS)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enviar,
    input  logic [8*BYTES_PONT-1:0] pontuacao,
    input  logic [7:0]              nave_opcode,
    input  logic [8*BYTES_POS-1:0]  nave_pos,
    input  logic [7:0]              jogada_especial,
    output logic [AW_A-1:0]         aste_end,
    input  logic [REG_W-1:0]        aste_dado,
    output logic [AW_T-1:0]         tiro_end,
    input  logic [REG_W-1:0]        tiro_dado,
    output logic [7:0]              tx_dado,
    output logic                    tx_partida,
    input  logic                    tx_fim,
    output logic                    ocupado,
    output logic                    pronto,
    output logic [4:0]              db_estado
);

    localparam int MAXB_A = (BYTES_PONT > BYTES_POS + 1) ? BYTES_PONT : BYTES_POS + 1;
    localparam int MAXB   = (MAXB_A > BYTES_RODAPE) ? MAXB_A : BYTES_RODAPE;
    localparam int IW     = $clog2(MAXB) + 1;
    localparam int MAXS   = (N_ASTE > N_TIROS) ? N_ASTE : N_TIROS;
    localparam int SW     = $clog2(MAXS) + 1;
    localparam int VALIDO = bit_valido(BYTES_POS);

    logic [4:0]              estado;
    logic [2:0]              secao;
    logic [IW-1:0]           idx;
    logic [SW-1:0]           slot;
    logic [IW-1:0]           ult_idx;
    logic [SW-1:0]           ult_slot;
    logic [8*BYTES_PONT-1:0] pont_s;
    logic [7:0]              nave_op_s;
    logic [8*BYTES_POS-1:0]  nave_pos_s;
    logic [7:0]              especial_s;
    logic [REG_W-1:0]        reg_obj;
    logic [7:0]              byte_sel;
    logic                    em_obj;

    assign em_obj     = (secao == S_ASTE) || (secao == S_TIRO);
    assign tx_partida = (estado == E_INICIA_TX);
    assign pronto     = (estado == E_FIM);
    assign ocupado    = (estado != E_INICIAL) && (estado != E_ESPERA) &&
                        (estado != E_ERRO);
    assign db_estado  = estado;
    assign aste_end   = (secao == S_ASTE) ? slot[AW_A-1:0] : '0;
    assign tiro_end   = (secao == S_TIRO) ? slot[AW_T-1:0] : '0;

    // Terminal counts for the byte and slot counters of each section
    always_comb begin
        ult_idx  = '0;
        ult_slot = '0;
        case (secao)
            S_PONT:     ult_idx = IW'(BYTES_PONT - 1);
            S_NAVE_POS: ult_idx = IW'(BYTES_POS - 1);
            S_ASTE: begin
                ult_idx  = IW'(BYTES_POS);
                ult_slot = SW'(N_ASTE - 1);
            end
            S_TIRO: begin
                ult_idx  = IW'(BYTES_POS);
                ult_slot = SW'(N_TIROS - 1);
            end
            S_RODAPE:   ult_idx = IW'(BYTES_RODAPE - 1);
            default:    ult_idx = '0;
        endcase
    end

    seletor_byte_quadro #(
        .BYTES_POS   (BYTES_POS),
        .BYTES_PONT  (BYTES_PONT),
        .RODAPE_BYTE (RODAPE_BYTE),
        .IW          (IW)
    ) u_sel (
        .secao    (secao),
        .idx      (idx),
        .pont     (pont_s),
        .nave_op  (nave_op_s),
        .nave_pos (nave_pos_s),
        .especial (especial_s),
        .obj      (reg_obj[REG_W-2:0]),
        .byte_out (byte_sel)
    );

    // Frame sequencer: state, counters, snapshot and TX byte register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado     <= E_INICIAL;
            secao      <= S_PONT;
            idx        <= '0;
            slot       <= '0;
            tx_dado    <= '0;
            pont_s     <= '0;
            nave_op_s  <= '0;
            nave_pos_s <= '0;
            especial_s <= '0;
            reg_obj    <= '0;
        end else begin
            case (estado)
                E_INICIAL: estado <= E_ESPERA;
                E_ESPERA:  if (enviar) estado <= E_CAPTURA;
                E_CAPTURA: begin
                    pont_s     <= pontuacao;
                    nave_op_s  <= nave_opcode;
                    nave_pos_s <= nave_pos;
                    especial_s <= jogada_especial;
                    secao      <= S_PONT;
                    idx        <= '0;
                    slot       <= '0;
                    estado     <= E_CARREGA;
                end
                E_CARREGA: begin
                    tx_dado <= byte_sel;
                    estado  <= E_INICIA_TX;
                end
                E_INICIA_TX: estado <= E_ESPERA_TX;
                E_ESPERA_TX: if (tx_fim) estado <= E_PROXIMO;
                E_PROXIMO: begin
                    if (idx != ult_idx) begin
                        idx    <= idx + 1'b1;
                        estado <= E_CARREGA;
                    end else begin
                        idx <= '0;
                        if (em_obj && slot != ult_slot) begin
                            slot   <= slot + 1'b1;
                            estado <= E_LE_MEM;
                        end else if (secao == S_RODAPE) begin
                            estado <= E_FIM;
                        end else begin
                            secao  <= secao + 3'd1;
                            slot   <= '0;
                            estado <= (secao == S_NAVE_POS || secao == S_ASTE)
                                      ? E_LE_MEM : E_CARREGA;
                        end
                    end
                end
                E_LE_MEM: estado <= E_ESPERA_MEM;
                E_ESPERA_MEM: begin
                    reg_obj <= (secao == S_ASTE) ? aste_dado : tiro_dado;
                    estado  <= E_VERIFICA;
                end
                E_VERIFICA: begin
                    if (reg_obj[VALIDO]) begin
                        idx    <= '0;
                        estado <= E_CARREGA;
                    end else if (slot != ult_slot) begin
                        slot   <= slot + 1'b1;
                        estado <= E_LE_MEM;
                    end else begin
                        secao  <= secao + 3'd1;
                        slot   <= '0;
                        estado <= (secao == S_ASTE) ? E_LE_MEM : E_CARREGA;
                    end
                end
                E_FIM:   estado <= E_ESPERA;
                E_ERRO:  estado <= E_ESPERA;
                default: estado <= E_ERRO;
            endcase
        end
    end

endmodule

// File: tb/tb_envia_quadro_serial.sv
// Directed bench for envia_quadro_serial: default instance plus a
// minimal 1-slot / 1-byte instance, with TX and memory models.
module tb_envia_quadro_serial;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;

    logic        enviar;
    logic [15:0] pontuacao;
    logic [7:0]  nave_opcode;
    logic [15:0] nave_pos;
    logic [7:0]  jogada_especial;
    logic [2:0]  aste_end;
    logic [24:0] aste_dado = '0;
    logic [1:0]  tiro_end;
    logic [24:0] tiro_dado = '0;
    logic [7:0]  tx_dado;
    logic        tx_partida;
    logic        tx_fim;
    logic        ocupado;
    logic        pronto;
    logic [4:0]  db_estado;
    logic        fim_mod = 1'b0;
    logic        fim_extra;
    logic [24:0] aste_mem [8];
    logic [24:0] tiro_mem [4];

    logic        enviar2;
    logic [7:0]  pont2;
    logic [7:0]  op2;
    logic [7:0]  pos2;
    logic [7:0]  esp2;
    logic [0:0]  ae2;
    logic [16:0] ad2 = '0;
    logic [0:0]  te2;
    logic [16:0] td2 = '0;
    logic [7:0]  txd2;
    logic        txp2;
    logic        txf2 = 1'b0;
    logic        ocu2;
    logic        pro2;
    logic [4:0]  est2;
    logic [16:0] aste_m2;
    logic [16:0] tiro_m2;

    int errors = 0;
    int checks = 0;
    int cnt1 = 0;
    int cnt2 = 0;
    int np1 = 0;
    int np2 = 0;
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    logic [7:0] exp1[$];
    logic [7:0] exp2[$];
    logic [7:0] exp3[$];

    assign tx_fim = fim_mod | fim_extra;

    envia_quadro_serial dut (
        .clock           (clock),
        .reset           (reset),
        .enviar          (enviar),
        .pontuacao       (pontuacao),
        .nave_opcode     (nave_opcode),
        .nave_pos        (nave_pos),
        .jogada_especial (jogada_especial),
        .aste_end        (aste_end),
        .aste_dado       (aste_dado),
        .tiro_end        (tiro_end),
        .tiro_dado       (tiro_dado),
        .tx_dado         (tx_dado),
        .tx_partida      (tx_partida),
        .tx_fim          (tx_fim),
        .ocupado         (ocupado),
        .pronto          (pronto),
        .db_estado       (db_estado)
    );

    envia_quadro_serial #(
        .N_ASTE     (1),
        .N_TIROS    (1),
        .BYTES_POS  (1),
        .BYTES_PONT (1)
    ) dut2 (
        .clock           (clock),
        .reset           (reset),
        .enviar          (enviar2),
        .pontuacao       (pont2),
        .nave_opcode     (op2),
        .nave_pos        (pos2),
        .jogada_especial (esp2),
        .aste_end        (ae2),
        .aste_dado       (ad2),
        .tiro_end        (te2),
        .tiro_dado       (td2),
        .tx_dado         (txd2),
        .tx_partida      (txp2),
        .tx_fim          (txf2),
        .ocupado         (ocu2),
        .pronto          (pro2),
        .db_estado       (est2)
    );

    // Synchronous-read object memories
    always @(posedge clock) begin
        aste_dado <= aste_mem[aste_end];
        tiro_dado <= tiro_mem[tiro_end];
        ad2       <= aste_m2;
        td2       <= tiro_m2;
    end

    // TX models: log each started byte, answer tx_fim 2 cycles later
    always @(posedge clock) begin
        if (tx_partida) begin
            q1.push_back(tx_dado);
            cnt1 <= 2;
        end else if (cnt1 > 0) begin
            cnt1 <= cnt1 - 1;
        end
        fim_mod <= (cnt1 == 1);
        if (pronto) np1 <= np1 + 1;
        if (txp2) begin
            q2.push_back(txd2);
            cnt2 <= 2;
        end else if (cnt2 > 0) begin
            cnt2 <= cnt2 - 1;
        end
        txf2 <= (cnt2 == 1);
        if (pro2) np2 <= np2 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_frame(input string tag, input logic [7:0] got[$],
                             input logic [7:0] expq[$]);
        chk({tag, "_len"}, got.size(), expq.size());
        for (int i = 0; i < expq.size(); i++)
            chk($sformatf("%s_b%0d", tag, i),
                (i < got.size()) ? {24'h0, got[i]} : 32'hFFFF_FFFF,
                {24'h0, expq[i]});
    endtask

    task automatic start(input int inst);
        @(negedge clock);
        if (inst == 1) enviar = 1'b1;
        else enviar2 = 1'b1;
        @(negedge clock);
        enviar  = 1'b0;
        enviar2 = 1'b0;
    endtask

    task automatic wait_frame(input string tag, input int inst);
        int n0;
        bit ok;
        n0 = (inst == 1) ? np1 : np2;
        ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clock);
            if (((inst == 1) ? np1 : np2) != n0) ok = 1'b1;
        end
        chk({tag, "_done"}, {31'h0, ok}, 32'd1);
    endtask

    task automatic wait_estado(input string tag, input logic [4:0] st);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 500 && !ok; c++) begin
            @(negedge clock);
            if (db_estado == st) ok = 1'b1;
        end
        chk(tag, {31'h0, ok}, 32'd1);
    endtask

    task automatic wait_bytes(input string tag, input int n);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 1000 && !ok; c++) begin
            @(negedge clock);
            if (q1.size() >= n) ok = 1'b1;
        end
        chk(tag, {31'h0, ok}, 32'd1);
    endtask

    initial begin
        int n;
        reset = 1'b0;
        enviar = 1'b0;
        enviar2 = 1'b0;
        fim_extra = 1'b0;
        pontuacao = 16'h1234;
        nave_opcode = 8'hA1;
        nave_pos = 16'h0506;
        jogada_especial = 8'h3C;
        for (int i = 0; i < 8; i++) aste_mem[i] = '0;
        for (int i = 0; i < 4; i++) tiro_mem[i] = '0;
        pont2 = 8'h5A;
        op2 = 8'h11;
        pos2 = 8'h22;
        esp2 = 8'h88;
        aste_m2 = {1'b1, 8'h44, 8'h55};
        tiro_m2 = {1'b1, 8'h66, 8'h77};
        exp1 = '{8'h12, 8'h34, 8'hA1, 8'h05, 8'h06, 8'h3C, 8'hFF, 8'hFF};
        exp2 = '{8'h12, 8'h34, 8'hA1, 8'h05, 8'h06,
                 8'hB2, 8'h21, 8'h22, 8'hB5, 8'h25, 8'h26,
                 8'hC3, 8'h33, 8'h34, 8'h3C, 8'hFF, 8'hFF};
        exp3 = '{8'h5A, 8'h11, 8'h22, 8'h44, 8'h55,
                 8'h66, 8'h77, 8'h88, 8'hFF, 8'hFF};

        repeat (2) @(negedge clock);
        chk("rst_tx_dado", tx_dado, 0);
        chk("rst_partida", tx_partida, 0);
        chk("rst_ocupado", ocupado, 0);
        chk("rst_pronto", pronto, 0);
        chk("rst_aste_end", aste_end, 0);
        chk("rst_tiro_end", tiro_end, 0);
        chk("rst_estado", db_estado, 0);

        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("espera", db_estado, 1);

        enviar = 1'b1;
        @(negedge clock);
        enviar = 1'b0;
        chk("captura", db_estado, 2);
        chk("captura_ocupado", ocupado, 1);
        chk("captura_partida", tx_partida, 0);
        @(negedge clock);
        chk("carrega", db_estado, 3);
        chk("carrega_partida", tx_partida, 0);
        @(negedge clock);
        chk("primeira_partida", tx_partida, 1);
        wait_frame("f1", 1);
        chk_frame("f1", q1, exp1);
        chk("f1_pronto", np1, 1);
        chk("f1_livre", ocupado, 0);

        aste_mem[2] = {1'b1, 8'hB2, 16'h2122};
        aste_mem[5] = {1'b1, 8'hB5, 16'h2526};
        tiro_mem[3] = {1'b1, 8'hC3, 16'h3334};
        q1.delete();
        start(1);
        wait_frame("f2", 1);
        chk_frame("f2", q1, exp2);

        aste_mem[2] = '0;
        aste_mem[5] = '0;
        tiro_mem[3] = '0;
        q1.delete();
        start(1);
        wait_bytes("snap_wait", 1);
        pontuacao = 16'hDEAD;
        nave_pos = 16'hBEEF;
        nave_opcode = 8'h00;
        jogada_especial = 8'h00;
        wait_frame("snap", 1);
        chk_frame("snap", q1, exp1);
        pontuacao = 16'h1234;
        nave_pos = 16'h0506;
        nave_opcode = 8'hA1;
        jogada_especial = 8'h3C;

        q1.delete();
        n = np1;
        start(1);
        wait_estado("ign_esp_tx", 5'd5);
        enviar = 1'b1;
        @(negedge clock);
        enviar = 1'b0;
        wait_estado("ign_ini_tx", 5'd4);
        fim_extra = 1'b1;
        @(negedge clock);
        fim_extra = 1'b0;
        wait_frame("ign", 1);
        chk_frame("ign", q1, exp1);
        repeat (40) @(negedge clock);
        chk("ign_bytes", q1.size(), 8);
        chk("ign_pronto", np1, n + 1);
        chk("ign_livre", ocupado, 0);

        aste_mem[2] = {1'b1, 8'hB2, 16'h2122};
        aste_mem[5] = {1'b1, 8'hB5, 16'h2526};
        tiro_mem[3] = {1'b1, 8'hC3, 16'h3334};
        q1.delete();
        start(1);
        wait_bytes("rst_mid_wait", 6);
        reset = 1'b0;
        #1;
        chk("rstm_partida", tx_partida, 0);
        chk("rstm_pronto", pronto, 0);
        chk("rstm_ocupado", ocupado, 0);
        chk("rstm_tx_dado", tx_dado, 0);
        chk("rstm_estado", db_estado, 0);
        chk("rstm_aste_end", aste_end, 0);
        repeat (5) @(negedge clock);
        chk("rstm_sem_bytes", q1.size(), 6);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        q1.delete();
        start(1);
        wait_frame("pos_rst", 1);
        chk_frame("pos_rst", q1, exp2);

        start(2);
        wait_frame("min", 2);
        chk_frame("min", q2, exp3);
        chk("min_pronto", np2, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
